// File: rtl/lut_arbiter.sv
// lut_arbiter: round-robin sharing of one registered-read lookup ROM among
// N_REQ requesters. One lookup per cycle issued to the ROM. The requester id
// travels alongside the read. Each requester owns a held response register
// with a valid/ready handshake. ROM_LAT must be at least 1.
module lut_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          req_ready,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [N_REQ*DATA_W-1:0]   rsp_data,
  input  logic [N_REQ-1:0]          rsp_ready
);

  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW   = ID_W + 1;
  // Stage 0 is loaded with rom_addr; the last stage lines up with rom_data.
  localparam int unsigned NS   = ROM_LAT + 1;

  logic [N_REQ-1:0][ADDR_W-1:0] addr_a;
  logic [ID_W-1:0]              ptr_q, ptr_d;
  logic [ADDR_W-1:0]            rom_addr_q;
  logic [NS-1:0]                stg_vld_q;
  logic [NS-1:0][ID_W-1:0]      stg_id_q;
  logic [N_REQ-1:0]             rsp_valid_q, rsp_valid_d;
  logic [N_REQ-1:0][DATA_W-1:0] rsp_data_q;

  logic [N_REQ-1:0]             busy;
  logic [N_REQ-1:0]             eligible;
  logic [N_REQ-1:0]             grant;
  logic                         grant_any;
  logic [ID_W-1:0]              grant_id;
  logic [CW-1:0]                cand;
  logic [CW-1:0]                ptr_inc;

  assign addr_a    = req_addr;
  assign eligible  = req_valid & ~busy;
  assign req_ready = grant;
  assign rom_addr  = rom_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // A requester is busy while its lookup is in the pipeline or its response is held.
  always_comb begin
    busy = rsp_valid_q;
    for (int unsigned s = 0; s < NS; s++) begin
      if (stg_vld_q[s]) begin
        busy[stg_id_q[s]] = 1'b1;
      end
    end
  end

  // Round-robin search starting at ptr, wrapping modulo N_REQ; first eligible wins.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + CW'(k);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (!grant_any && eligible[cand[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand[ID_W-1:0];
      end
    end
    if (grant_any) begin
      grant[grant_id] = 1'b1;
    end
  end

  // Next pointer follows the granted index; response valids clear on ack and set on capture.
  always_comb begin
    ptr_inc = {1'b0, grant_id} + CW'(1);
    if (ptr_inc == CW'(N_REQ)) begin
      ptr_inc = '0;
    end
    ptr_d = grant_any ? ptr_inc[ID_W-1:0] : ptr_q;

    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    if (stg_vld_q[NS-1]) begin
      rsp_valid_d[stg_id_q[NS-1]] = 1'b1;
    end
  end

  // Registered state: pointer, ROM address, id pipeline and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rom_addr_q  <= '0;
      stg_vld_q   <= '0;
      stg_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      if (grant_any) begin
        rom_addr_q <= addr_a[grant_id];
      end
      stg_vld_q   <= {stg_vld_q[NS-2:0], grant_any};
      stg_id_q    <= {stg_id_q[NS-2:0], grant_id};
      rsp_valid_q <= rsp_valid_d;
      if (stg_vld_q[NS-1]) begin
        rsp_data_q[stg_id_q[NS-1]] <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_lut_arbiter.sv
// tb_lut_arbiter: directed vectors with a scoreboard. Stimulus pushes the
// hand-computed response for every grant it expects; a monitor pops and
// compares whenever a requester presents a new response.
module tb_lut_arbiter;

  localparam int N  = 4;
  localparam int AW = 7;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_data;
  logic [N-1:0]    rsp_ready;

  lut_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  // ROM model: entry k = 0xA500_0000 + k, one-cycle registered read.
  always @(posedge clk) rom_data <= 32'hA500_0000 + {25'd0, rom_addr};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {int id; logic [31:0] data;} exp_t;
  typedef struct {int id; int cyc;} acc_t;
  exp_t exp_q[$];
  acc_t acc_q[$];

  logic [31:0] exp_dat [N];
  logic [N-1:0] prev_hold = '0;
  logic [31:0]  held [N];

  // Accept logger: remembers the cycle of every handshake for latency checks.
  acc_t lg_a;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          lg_a.id  = i;
          lg_a.cyc = cyc;
          acc_q.push_back(lg_a);
        end
      end
    end
  end

  // Monitor: new responses are popped from the scoreboard; held ones must stay stable.
  int          mon_e, mon_a;
  logic [31:0] mon_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        mon_d = rsp_data[i*DW +: DW];
        if (rsp_valid[i] && !prev_hold[i]) begin
          mon_e = -1;
          mon_a = -1;
          for (int k = 0; k < exp_q.size(); k++)
            if (mon_e < 0 && exp_q[k].id == i) mon_e = k;
          for (int k = 0; k < acc_q.size(); k++)
            if (mon_a < 0 && acc_q[k].id == i) mon_a = k;
          if (mon_e < 0) begin
            checks++;
            failures++;
            $display("FAIL stray_rsp[%0d] @cyc %0d: got %h expected no response", i, cyc, mon_d);
          end else begin
            chk($sformatf("rsp_data[%0d]", i), mon_d, exp_q[mon_e].data);
            exp_q.delete(mon_e);
          end
          if (mon_a >= 0) begin
            chk($sformatf("latency[%0d]", i), 32'(cyc - acc_q[mon_a].cyc), 32'd3);
            acc_q.delete(mon_a);
          end
        end else if (prev_hold[i]) begin
          chk($sformatf("hold_valid[%0d]", i), 32'(rsp_valid[i]), 32'd1);
          chk($sformatf("hold_data[%0d]", i), mon_d, held[i]);
        end
        prev_hold[i] = rsp_valid[i] && !rsp_ready[i];
        held[i]      = mon_d;
      end
    end
  end

  // One cycle of stimulus: drive, check the grant mid-cycle, push expected responses.
  task automatic run_vec(input logic [3:0] v, input logic [3:0] rr, input logic [3:0] g);
    exp_t e;
    req_valid = v;
    rsp_ready = rr;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(g));
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        e.id   = i;
        e.data = exp_dat[i];
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [6:0] a3, input logic [6:0] a2,
                          input logic [6:0] a1, input logic [6:0] a0);
    req_addr = {a3, a2, a1, a0};
  endtask

  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    req_valid = '0;
    exp_q.delete();
    acc_q.delete();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [3:0] g_bp [15];

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = '0;
    for (int i = 0; i < N; i++) exp_dat[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < N; i++) chk($sformatf("rst_rsp_data[%0d]", i), rsp_data[i*DW +: DW], 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);

    // Single request from requester 2
    set_addr(7'h00, 7'h05, 7'h00, 7'h00);
    exp_dat[2] = 32'hA500_0005;
    run_vec(4'b0100, 4'b1111, 4'b0100);
    chk("single_rom_addr", 32'(rom_addr), 32'h05);
    repeat (5) run_vec(4'b0000, 4'b1111, 4'b0000);

    // Full contention from reset: grants rotate every cycle
    do_reset(1);
    set_addr(7'h13, 7'h12, 7'h11, 7'h10);
    for (int i = 0; i < N; i++) exp_dat[i] = 32'hA500_0010 + 32'(i);
    for (int c = 0; c < 12; c++) run_vec(4'b1111, 4'b1111, 4'(1 << (c % 4)));
    repeat (6) run_vec(4'b0000, 4'b1111, 4'b0000);

    // Fairness between requesters 1 and 3 with wrap
    set_addr(7'h33, 7'h00, 7'h31, 7'h00);
    exp_dat[1] = 32'hA500_0031;
    exp_dat[3] = 32'hA500_0033;
    for (int c = 0; c < 12; c++)
      run_vec(4'b1010, 4'b1111, (c % 4 == 0) ? 4'b0010 : (c % 4 == 1) ? 4'b1000 : 4'b0000);
    repeat (6) run_vec(4'b0000, 4'b1111, 4'b0000);

    // Backpressure on requester 0 while requester 1 keeps being served
    set_addr(7'h00, 7'h00, 7'h40, 7'h7F);
    exp_dat[0] = 32'hA500_007F;
    exp_dat[1] = 32'hA500_0040;
    for (int c = 0; c < 15; c++) g_bp[c] = 4'b0000;
    g_bp[0] = 4'b0001; g_bp[1] = 4'b0010; g_bp[5] = 4'b0010; g_bp[9] = 4'b0010;
    g_bp[13] = 4'b0010; g_bp[14] = 4'b0001;
    for (int c = 0; c < 15; c++) begin
      if (c == 12) begin
        chk("bp_held_valid", 32'(rsp_valid[0]), 32'd1);
        chk("bp_held_data", rsp_data[31:0], 32'hA500_007F);
      end
      if (c == 14) begin
        chk("bp_acked_valid", 32'(rsp_valid[0]), 32'd0);
        chk("bp_retained_data", rsp_data[31:0], 32'hA500_007F);
      end
      run_vec(4'b0011, (c < 13) ? 4'b1110 : 4'b1111, g_bp[c]);
    end
    repeat (5) run_vec(4'b0000, 4'b1111, 4'b0000);

    // Reset one cycle after accepting a lookup from requester 1
    set_addr(7'h00, 7'h00, 7'h22, 7'h00);
    exp_dat[1] = 32'hA500_0022;
    run_vec(4'b0010, 4'b1111, 4'b0010);
    chk("flight_rom_addr", 32'(rom_addr), 32'h22);
    rst_n     = 1'b0;
    req_valid = '0;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    repeat (4) run_vec(4'b0000, 4'b1111, 4'b0000);
    set_addr(7'h53, 7'h52, 7'h51, 7'h50);
    exp_dat[0] = 32'hA500_0050;
    run_vec(4'b1111, 4'b0000, 4'b0001);
    repeat (2) run_vec(4'b0000, 4'b0000, 4'b0000);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'b0001);

    // Idle with a held response
    repeat (20) begin
      run_vec(4'b0000, 4'b0000, 4'b0000);
      chk("idle_rom_addr", 32'(rom_addr), 32'h50);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'b0001);
    end
    repeat (3) run_vec(4'b0000, 4'b1111, 4'b0000);
    chk("final_rsp_valid", 32'(rsp_valid), 32'd0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("acc_q_drained", 32'(acc_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/lut_arbiter.md
Name: lut_arbiter

Overview:
- Shares one registered-read lookup ROM (1-cycle read latency, 2^ADDR_W × DATA_W) between N_REQ requesters, such as synth voices fetching wavetable or phase-increment entries.
- Sits between the requesters and the ROM instance.
- Arbitration is round-robin. The ROM can accept one lookup per cycle, and the arbiter keeps it fed at that rate.
- Each requester gets its own held response with a valid/ready handshake.

Parameters:
- N_REQ, 4: number of requesters (≥2).
- ADDR_W, 7: ROM address width.
- DATA_W, 32: ROM data width.
- ROM_LAT, 1: read latency of the attached ROM, in cycles.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  N_REQ  per-requester lookup request.
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_ready  out  N_REQ  one-hot (or zero) grant; request accepted when req_valid[i] & req_ready[i].
- rom_addr  out  ADDR_W  registered address to the ROM.
- rom_data  in  DATA_W  ROM read data.
- rsp_valid  out  N_REQ  per-requester response held valid.
- rsp_data  out  N_REQ*DATA_W  packed per-requester response registers.
- rsp_ready  in  N_REQ  per-requester response acknowledge.

Behaviour:
- Reset (rst_n low at a clock edge) clears all state. After the edge:
  - rsp_valid = 0, rsp_data = 0, rom_addr = 0;
  - in-flight pipeline empty;
  - round-robin pointer ptr = 0.
- Reset mid-operation: in-flight lookups are discarded, and no rsp_valid is raised for them afterwards.
- busy[i] = lookup for i in flight OR rsp_valid[i]. eligible[i] = req_valid[i] & !busy[i].
- Grant selection: the first eligible index searching ptr, ptr+1, … with wrap modulo N_REQ.
  - req_ready is combinational from req_valid and registered state. At most one bit is high, and only for an eligible requester.
- On an accepted request from g in cycle T:
  - rom_addr <= req_addr[g];
  - the pipeline entry {valid, id = g} enters stage 0;
  - ptr <= (g+1) mod N_REQ, wrapping from N_REQ-1 to 0.
- No grant: ptr and rom_addr hold.
- Pipeline: the id travels ROM_LAT+1 register stages aligned with rom_data. At the last stage, rsp_data[id] <= rom_data and rsp_valid[id] <= 1.
- Latency: accept in cycle T gives rsp_valid high in cycle T+ROM_LAT+2 (T+3 at the default).
- Response hold: rsp_valid[i] and rsp_data[i] stay stable until a cycle with rsp_ready[i] high. rsp_valid[i] clears at that edge; rsp_data[i] retains its value.
- rsp_ready[i] while rsp_valid[i] is low is ignored.
- Acknowledge timing: an ack in cycle A makes requester i eligible from cycle A+1, not in A itself.
  - Per-requester peak rate is one lookup per ROM_LAT+3 cycles with immediate ack.
  - Aggregate peak rate is one lookup per cycle.
- One outstanding lookup per requester, so a capture and an ack never coincide for the same i.
- Lowering req_valid before the handshake carries no obligation; nothing is latched.
- All addresses 0…2^ADDR_W-1 are passed through unmodified.

Test Plan:
Bench ROM model: entry k = 0xA500_0000 + k; default parameters throughout.
- Single request: requester 2, addr 0x05, rsp_ready held high → req_ready[2] high the same cycle; rsp_valid = 0100 at T+3 for exactly one cycle; rsp_data[2] = 0xA500_0005.
- Full contention: all four req_valid high from reset, addresses 0x10–0x13, immediate acks → grants 0,1,2,3 in consecutive cycles; responses at T+3…T+6 carry 0xA500_0010…13; each requester is re-granted after its ack.
- Fairness / wrap: requesters 1 and 3 always valid with immediate acks → grant order 1,3,1,3…; ptr wraps 3→0→1 with no extra idle cycle.
- Backpressure: requester 0 reads addr 0x7F with rsp_ready low for 10 cycles → rsp_valid[0] and rsp_data[0] = 0xA500_007F held stable; req_ready[0] stays 0 while requester 1 is still served; requester 0 is granted the cycle after the ack.
- Reset mid-flight: rst_n low for one cycle, one cycle after accepting addr 0x22 → all rsp_valid = 0, rom_addr = 0, no stray response; next grant starts from index 0.
- Idle: no req_valid for 20 cycles → req_ready = 0, rom_addr unchanged, rsp_valid unchanged.
